// File: rtl/shift_add_multiplier_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | shift_add_multiplier_pkg : shared width default and FSM encodings     |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package shift_add_multiplier_pkg;

  localparam int DEFAULT_N = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/shift_add_multiplier_adder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | four_bit_adder : parameterized N-bit ripple-carry adder               |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module four_bit_adder
  import shift_add_multiplier_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_cin,
  output logic [N-1:0] o_sum,
  output logic         o_cout
);

  logic [N:0] w_carry;

  assign w_carry[0] = i_cin;

  for (genvar i = 0; i < N; i++) begin : g_bit
    assign o_sum[i]     = i_a[i] ^ i_b[i] ^ w_carry[i];
    assign w_carry[i+1] = (i_a[i] & i_b[i]) | (w_carry[i] & (i_a[i] ^ i_b[i]));
  end

  assign o_cout = w_carry[N];

endmodule
`default_nettype wire

// File: rtl/shift_add_multiplier.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | shift_add_multiplier : sequential unsigned NxN shift-and-add multiply |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module shift_add_multiplier
  import shift_add_multiplier_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   A,
  input  logic [N-1:0]   B,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] Product
);

  localparam int CNT_W = $clog2(N) + 1;

  state_e           state_q, state_d;
  logic [N-1:0]     m_q, m_d;
  logic [N-1:0]     q_q, q_d;
  logic [N-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [2*N-1:0]   product_q, product_d;

  logic [N-1:0]     w_addend;
  logic [N-1:0]     w_sum;
  logic             w_cout;
  logic [2*N-1:0]   w_shifted;

  assign w_addend = q_q[0] ? m_q : '0;

  four_bit_adder #(.N(N)) u_adder (
    .i_a    (acc_q),
    .i_b    (w_addend),
    .i_cin  (1'b0),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // Carry-out becomes the new ACC MSB, so the 2N-bit window never drops a bit.
  assign w_shifted = {w_cout, w_sum, q_q[N-1:1]};

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    q_d       = q_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    product_d = product_q;

    case (state_q)
      // DONE lasts one cycle and may launch the next multiply on its exit edge,
      // giving one result every N+1 cycles under a held start.
      IDLE, DONE: begin
        if (start) begin
          m_d     = A;
          q_d     = B;
          acc_d   = '0;
          cnt_d   = CNT_W'(N);
          busy_d  = 1'b1;
          state_d = CALC;
        end else begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      CALC: begin
        acc_d = w_shifted[2*N-1:N];
        q_d   = w_shifted[N-1:0];
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d   = DONE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          product_d = w_shifted;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      m_q       <= '0;
      q_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      q_q       <= q_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      product_q <= product_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign Product = product_q;

endmodule
`default_nettype wire
